// File: rtl/fsm_start_arbiter.sv
// Round-robin arbiter that shares one start/done sequence FSM between
// N_REQ requesters. A winner gets a one-cycle start pulse to the FSM, the
// grant is held until the FSM reports done (or the timeout expires), then a
// one-cycle ack (plus err on timeout) is returned and a short gap follows.
// All outputs are registered from the next-state decode, so nothing is
// combinational from input to output.
module fsm_start_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic             busy,
  output logic             fsm_start,
  input  logic             fsm_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;        // last winner; also the current owner
  logic [CNT_W-1:0] cnt, cnt_nxt;        // cycles since the start pulse
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [N_REQ-1:0] gnt_nxt, ack_nxt;
  logic             err_nxt, busy_nxt, start_nxt;

  // First set request searching upward from the slot after the last winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = p;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // The timeout counter holds at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gap_nxt   = gap_cnt;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          ptr_nxt   = rr_pick(req, ptr);
          cnt_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        cnt_nxt   = sat_inc(cnt);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = sat_inc(cnt);
        // A done arriving on the last allowed cycle still counts as success.
        if (fsm_done) begin
          state_nxt = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        gap_nxt   = '0;
        state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        gap_nxt = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    start_nxt = (state_nxt == S_START);
    busy_nxt  = (state_nxt != S_IDLE);
    gnt_nxt   = (state_nxt == S_START || state_nxt == S_WAIT || state_nxt == S_DONE)
                ? one_hot(ptr_nxt) : '0;
    ack_nxt   = (state_nxt == S_DONE) ? one_hot(ptr_nxt) : '0;
  end

  // State, counters, pointer and output registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= PTR_INIT;
      cnt       <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      fsm_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gap_cnt   <= gap_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      fsm_start <= start_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_start_arbiter.sv
// Self-checking bench for fsm_start_arbiter: a per-cycle vector table,
// hand-written multi-cycle sequences, and randomized traffic, all compared
// against a transaction-timeline reference model.
module tb_fsm_start_arbiter;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int CW  = 4;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         fsm_done;
  logic [N-1:0] req, gnt, ack;
  logic         err, busy, fsm_start;

  int checks = 0;
  int passed = 0;
  int start_pulses = 0;

  // Reference model: time offset within the current transaction.
  int m_t;       // -1 idle, 0 = start cycle, then counts upward
  int m_ack_t;   // offset of the ack cycle
  bit m_err;
  int m_win;
  int m_ptr;

  typedef struct {
    logic [N-1:0] rq;
    logic         dn;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_ack;
    logic         e_err;
    logic         e_busy;
    logic         e_start;
  } vec_t;

  vec_t tbl [12];
  int   order [5];

  always #10 clk = ~clk;

  fsm_start_arbiter #(
    .N_REQ(N), .TIMEOUT(TO), .CNT_W(CW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .ack(ack), .err(err),
    .busy(busy), .fsm_start(fsm_start), .fsm_done(fsm_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_t = -1; m_ack_t = 0; m_err = 1'b0; m_win = 0; m_ptr = N - 1;
  endfunction

  function automatic void model_update();
    if (m_t < 0) begin
      if (req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (req[(m_ptr + i) % N]) begin
            m_win = (m_ptr + i) % N;
            break;
          end
        end
        m_ptr = m_win; m_t = 0; m_ack_t = TO; m_err = 1'b1;
      end
    end else begin
      if (m_t >= 1 && m_t < m_ack_t && fsm_done) begin
        m_ack_t = m_t + 1; m_err = 1'b0;
      end
      m_t++;
      if (m_t > m_ack_t + GAP) m_t = -1;
    end
  endfunction

  function automatic logic [10:0] model_out();
    logic [N-1:0] oh, g, a;
    oh = N'(1 << m_win);
    g  = (m_t >= 0 && m_t <= m_ack_t) ? oh : '0;
    a  = (m_t >= 0 && m_t == m_ack_t) ? oh : '0;
    return {g, a, (m_t >= 0 && m_t == m_ack_t && m_err), (m_t >= 0), (m_t == 0)};
  endfunction

  task automatic check_model();
    if (fsm_start === 1'b1) start_pulses++;
    chk("model_outputs", 32'({gnt, ack, err, busy, fsm_start}), 32'(model_out()));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (fsm_start !== 1'b1 && n < 30) begin tick(); n++; end
    chk(name, 32'(fsm_start), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin tick(); n++; end
    chk("drain_idle", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, base, w;
    reset = 1'b0; req = '0; fsm_done = 1'b0;
    model_reset();
    #5 reset = 1'b1;
    model_reset();

    // Reset held with every request raised: all outputs stay low.
    req = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", 32'({gnt, ack, err, busy, fsm_start}), 32'd0);
    end
    reset = 1'b0;

    // Round-robin with all requesters pending: 0,1,2,3,0.
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    base = start_pulses;
    tick();
    chk("first_gnt_after_reset", 32'(gnt), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_start("rr_start_seen");
      chk("rr_order_gnt", 32'(gnt), 32'(1 << order[k]));
      tick(); tick();
      fsm_done = 1'b1;
      tick();
      fsm_done = 1'b0;
      chk("rr_ack", 32'(ack), 32'(1 << order[k]));
      if (k == 4) begin
        req = '0;
      end else begin
        w = order[k];
        req[w] = 1'b0;
        tick();
        req[w] = 1'b1;
      end
    end
    drain();
    chk("rr_start_count", 32'(start_pulses - base), 32'd5);

    // Single requester, done five cycles after start.
    tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].rq;
      fsm_done = tbl[i].dn;
      chk($sformatf("table_row%0d", i), 32'({gnt, ack, err, busy, fsm_start}),
          32'({tbl[i].e_gnt, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_busy, tbl[i].e_start}));
      tick();
    end
    fsm_done = 1'b0;

    // Timeout: no done, ack+err 16 cycles after start, then re-arbitration.
    req = 4'b0001;
    wait_start("timeout_start");
    n = 0;
    while (ack === '0 && n < 40) begin tick(); n++; end
    chk("timeout_latency", 32'(n), 32'd16);
    chk("timeout_ack", 32'(ack), 32'd1);
    chk("timeout_err", 32'(err), 32'd1);
    n = 0;
    while (fsm_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rearb_latency", 32'(n), 32'd4);

    // Done on the last allowed cycle wins over the timeout.
    for (int i = 0; i < 15; i++) tick();
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    req = '0;
    chk("done_at_last_ack", 32'(ack), 32'd1);
    chk("done_at_last_err", 32'(err), 32'd0);
    drain();

    // Done pulse while idle is ignored.
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_done_ignored", 32'({gnt, ack, err, busy, fsm_start}), 32'd0);
    end

    // Async reset during WAIT, then 0 before 3 after release.
    req = 4'b0010;
    wait_start("abort_start");
    tick(); tick();
    chk("abort_gnt_before", 32'(gnt), 32'd2);
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("abort_gnt_zero", 32'(gnt), 32'd0);
    chk("abort_busy_zero", 32'(busy), 32'd0);
    req = 4'b1001;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_reset_gnt0", 32'(gnt), 32'd1);
    tick();
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    chk("post_reset_ack0", 32'(ack), 32'd1);
    req[0] = 1'b0;
    wait_start("post_reset_start3");
    chk("post_reset_gnt3", 32'(gnt), 32'd8);
    tick();
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    req = '0;
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        #3 reset = 1'b1;
        model_reset();
        #1 check_model();
        tick();
        reset = 1'b0;
      end
      req = req & ~ack;
      if (gnt != '0 && $urandom_range(0, 15) == 0) req = req & ~gnt;
      for (int i = 0; i < N; i++)
        if (!req[i] && ack[i] !== 1'b1 && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      fsm_done = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
